// File: rtl/mdu_ctrl.sv
// HI/LO multiply-divide controller for the E stage.
// Sequences a multi-cycle multiply/divide on an external combinational
// arithmetic core. It owns the architectural HI/LO registers, serves
// mfhi/mflo reads and stalls the front of the pipeline while a result
// is pending.
//
// state | meaning
// ------+---------------------------------------------------------------
// IDLE  | no operation running; accepts mult/div starts and mthi/mtlo
// RUN   | operands latched, counting down to the HI/LO commit edge
module mdu_ctrl #(
  parameter int MULT_LAT = 5,
  parameter int DIV_LAT  = 10
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [3:0]  e_op,
  input  logic [31:0] e_rs,
  input  logic [31:0] e_rt,
  input  logic        d_uses_md,
  input  logic        cancel,
  output logic [31:0] core_a,
  output logic [31:0] core_b,
  output logic [1:0]  core_op,
  input  logic [31:0] core_hi,
  input  logic [31:0] core_lo,
  output logic [31:0] hi,
  output logic [31:0] lo,
  output logic [31:0] e_rd_data,
  output logic        busy,
  output logic        stall
);

  localparam int MAX_LAT = (MULT_LAT > DIV_LAT) ? MULT_LAT : DIV_LAT;
  localparam int CNT_W   = $clog2(MAX_LAT + 1);

  localparam logic [CNT_W-1:0] MULT_LD = CNT_W'(MULT_LAT);
  localparam logic [CNT_W-1:0] DIV_LD  = CNT_W'(DIV_LAT);
  localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

  localparam logic [3:0] OP_MULT  = 4'd1;
  localparam logic [3:0] OP_MULTU = 4'd2;
  localparam logic [3:0] OP_DIVU  = 4'd4;
  localparam logic [3:0] OP_MTHI  = 4'd5;
  localparam logic [3:0] OP_MTLO  = 4'd6;
  localparam logic [3:0] OP_MFHI  = 4'd7;
  localparam logic [3:0] OP_MFLO  = 4'd8;

  typedef enum logic {
    IDLE = 1'b0,
    RUN  = 1'b1
  } state_t;

  state_t           state, state_nxt;
  logic [CNT_W-1:0] cnt, cnt_nxt;
  logic             start;
  logic             commit;
  logic             wr_hi;
  logic             wr_lo;
  logic             is_arith;
  logic             is_mult;

  // Decode the E-stage op into arithmetic class; 9-15 fall out as none.
  always_comb begin
    is_arith = (e_op >= OP_MULT) && (e_op <= OP_DIVU);
    is_mult  = (e_op == OP_MULT) || (e_op == OP_MULTU);
  end

  // Next-state, counter and strobe logic; cancel suppresses everything.
  always_comb begin
    state_nxt = state;
    cnt_nxt   = cnt;
    start     = 1'b0;
    commit    = 1'b0;
    wr_hi     = 1'b0;
    wr_lo     = 1'b0;
    case (state)
      IDLE: begin
        if (!cancel) begin
          if (is_arith) begin
            start     = 1'b1;
            state_nxt = RUN;
            cnt_nxt   = is_mult ? MULT_LD : DIV_LD;
          end
          wr_hi = (e_op == OP_MTHI);
          wr_lo = (e_op == OP_MTLO);
        end
      end
      RUN: begin
        // Any new op arriving here is ignored; the pipeline holds it via stall.
        if (cancel) begin
          state_nxt = IDLE;
          cnt_nxt   = '0;
        end else if (cnt == CNT_ONE) begin
          commit    = 1'b1;
          state_nxt = IDLE;
          cnt_nxt   = '0;
        end else begin
          cnt_nxt = cnt - CNT_ONE;
        end
      end
      default: begin
        state_nxt = IDLE;
        cnt_nxt   = '0;
      end
    endcase
  end

  // State and countdown register.
  always_ff @(posedge clk) begin
    if (reset) begin
      state <= IDLE;
      cnt   <= '0;
    end else begin
      state <= state_nxt;
      cnt   <= cnt_nxt;
    end
  end

  // Operand latch for the arithmetic core, loaded only on a start edge.
  always_ff @(posedge clk) begin
    if (reset) begin
      core_a  <= '0;
      core_b  <= '0;
      core_op <= '0;
    end else if (start) begin
      core_a  <= e_rs;
      core_b  <= e_rt;
      core_op <= 2'(e_op - OP_MULT);
    end
  end

  // Architectural HI/LO: core result on the final count, else mthi/mtlo.
  always_ff @(posedge clk) begin
    if (reset) begin
      hi <= '0;
      lo <= '0;
    end else if (commit) begin
      hi <= core_hi;
      lo <= core_lo;
    end else begin
      if (wr_hi) hi <= e_rs;
      if (wr_lo) lo <= e_rs;
    end
  end

  // Status and read data straight from the current register values.
  always_comb begin
    busy  = (state == RUN);
    stall = d_uses_md & (busy | start);
    if (e_op == OP_MFHI) begin
      e_rd_data = hi;
    end else if (e_op == OP_MFLO) begin
      e_rd_data = lo;
    end else begin
      e_rd_data = '0;
    end
  end

endmodule

// File: tb/tb_mdu_ctrl.sv
// Randomized scoreboard bench for mdu_ctrl with a behavioural HI/LO model.
module tb_mdu_ctrl;

  localparam int MULT_LAT = 5;
  localparam int DIV_LAT  = 10;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic [3:0]  e_op = 4'd0;
  logic [31:0] e_rs = 32'd0;
  logic [31:0] e_rt = 32'd0;
  logic        d_uses_md = 1'b0;
  logic        cancel = 1'b0;
  logic [31:0] core_a, core_b, core_hi, core_lo, hi, lo, e_rd_data;
  logic [1:0]  core_op;
  logic        busy, stall;

  always #5 clk = ~clk;

  mdu_ctrl #(.MULT_LAT(MULT_LAT), .DIV_LAT(DIV_LAT)) dut (
    .clk(clk), .reset(reset), .e_op(e_op), .e_rs(e_rs), .e_rt(e_rt),
    .d_uses_md(d_uses_md), .cancel(cancel), .core_a(core_a), .core_b(core_b),
    .core_op(core_op), .core_hi(core_hi), .core_lo(core_lo), .hi(hi), .lo(lo),
    .e_rd_data(e_rd_data), .busy(busy), .stall(stall)
  );

  // Behavioural arithmetic core: {hi, lo}; quotient to LO, remainder to HI.
  function automatic logic [63:0] core_fn(input logic [1:0] op, input logic [31:0] a,
                                          input logic [31:0] b);
    logic signed [63:0] sa, sb, sq, sr;
    logic [63:0] res;
    sa = {{32{a[31]}}, a};
    sb = {{32{b[31]}}, b};
    res = 64'd0;
    case (op)
      2'd0: res = 64'(sa * sb);
      2'd1: res = {32'd0, a} * {32'd0, b};
      2'd2: begin
        if (b == 32'd0) res = {a, 32'hFFFFFFFF};
        else begin
          sq = sa / sb;
          sr = sa % sb;
          res = {sr[31:0], sq[31:0]};
        end
      end
      default: begin
        if (b == 32'd0) res = {a, 32'hFFFFFFFF};
        else res = {a % b, a / b};
      end
    endcase
    return res;
  endfunction

  always_comb {core_hi, core_lo} = core_fn(core_op, core_a, core_b);

  // Scoreboard event: a change to HI/LO (or an operation end) due at cycle 'due'.
  typedef struct {
    int          due;
    bit          wh;
    bit          wl;
    logic [31:0] h;
    logic [31:0] l;
    bit          ends;
  } ev_t;

  ev_t sb_q[$];

  int cyc = 0;
  int busy_start = 1;
  int busy_end = 0;
  bit exp_start = 1'b0;
  bit pending = 1'b0;
  logic [31:0] pend_h = 32'd0;
  logic [31:0] pend_l = 32'd0;
  bit started = 1'b0;
  bit done_req = 1'b0;
  bit done_chk = 1'b0;
  int n_pass = 0;
  int n_checks = 0;

  initial forever begin
    @(posedge clk);
    cyc++;
  end

  function automatic bit model_busy(input int c);
    return (c >= busy_start) && (c <= busy_end);
  endfunction

  task automatic push_ev(input bit wh, input bit wl, input logic [31:0] h,
                         input logic [31:0] l, input bit ends);
    ev_t e;
    e.due = cyc + 1;
    e.wh = wh;
    e.wl = wl;
    e.h = h;
    e.l = l;
    e.ends = ends;
    sb_q.push_back(e);
  endtask

  // Drive one cycle of E-stage inputs and predict its effect.
  task automatic drive(input logic [3:0] op, input logic [31:0] rs, input logic [31:0] rt,
                       input logic du, input logic cn);
    bit idle;
    int lat;
    logic [63:0] r;
    e_op = op;
    e_rs = rs;
    e_rt = rt;
    d_uses_md = du;
    cancel = cn;
    reset = 1'b0;
    idle = !model_busy(cyc);
    exp_start = 1'b0;
    if (!idle && pending) begin
      if (cn) begin
        push_ev(1'b0, 1'b0, 32'd0, 32'd0, 1'b1);
        busy_end = cyc;
        pending = 1'b0;
      end else if (cyc == busy_end) begin
        push_ev(1'b1, 1'b1, pend_h, pend_l, 1'b1);
        pending = 1'b0;
      end
    end
    if (idle && !cn) begin
      if (op >= 4'd1 && op <= 4'd4) begin
        lat = (op <= 4'd2) ? MULT_LAT : DIV_LAT;
        r = core_fn(2'(op - 4'd1), rs, rt);
        pend_h = r[63:32];
        pend_l = r[31:0];
        pending = 1'b1;
        busy_start = cyc + 1;
        busy_end = cyc + lat;
        exp_start = 1'b1;
      end else if (op == 4'd5) begin
        push_ev(1'b1, 1'b0, rs, 32'd0, 1'b0);
      end else if (op == 4'd6) begin
        push_ev(1'b0, 1'b1, 32'd0, rs, 1'b0);
      end
    end
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    bit was_busy;
    was_busy = model_busy(cyc);
    reset = 1'b1;
    e_op = 4'd0;
    d_uses_md = 1'b0;
    cancel = 1'b0;
    exp_start = 1'b0;
    push_ev(1'b1, 1'b1, 32'd0, 32'd0, was_busy);
    if (was_busy) busy_end = cyc;
    pending = 1'b0;
    @(posedge clk);
    #1;
    reset = 1'b0;
  endtask

  task automatic idle(input int n, input logic du);
    repeat (n) drive(4'd0, $urandom, $urandom, du, 1'b0);
  endtask

  function automatic logic [31:0] rnd_val();
    case ($urandom_range(0, 4))
      0: return 32'd0;
      1: return 32'($urandom_range(0, 15));
      2: return 32'h80000000;
      3: return 32'hFFFFFFFF;
      default: return $urandom;
    endcase
  endfunction

  // Monitor: applies due scoreboard events and compares every output each cycle.
  logic [31:0] m_hi = 32'd0;
  logic [31:0] m_lo = 32'd0;
  bit prev_busy = 1'b0;
  bit ended;
  bit exp_b;
  logic [31:0] exp_rd;
  ev_t ev;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s at cycle %0d: got %h expected %h", name, cyc, act, exp);
  endtask

  initial forever begin
    @(negedge clk);
    if (started) begin
      ended = 1'b0;
      while (sb_q.size() > 0 && sb_q[0].due <= cyc) begin
        ev = sb_q.pop_front();
        if (ev.wh) m_hi = ev.h;
        if (ev.wl) m_lo = ev.l;
        if (ev.ends) ended = 1'b1;
      end
      exp_b = model_busy(cyc);
      exp_rd = (e_op == 4'd7) ? m_hi : (e_op == 4'd8) ? m_lo : 32'd0;
      chk("busy", 32'(busy), 32'(exp_b));
      chk("stall", 32'(stall), 32'(d_uses_md & (exp_b | exp_start)));
      chk("hi", hi, m_hi);
      chk("lo", lo, m_lo);
      chk("e_rd_data", e_rd_data, exp_rd);
      if (prev_busy && !busy) chk("busy_fall_event", 32'(ended), 32'd1);
      prev_busy = busy;
      if (done_req && !done_chk) begin
        chk("queue_empty", 32'(sb_q.size()), 32'd0);
        done_chk = 1'b1;
      end
    end
  end

  initial begin
    reset = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    reset = 1'b0;
    started = 1'b1;

    // mult: 3 * -2
    drive(4'd1, 32'd3, 32'hFFFFFFFE, 1'b0, 1'b0);
    idle(7, 1'b0);
    // divu 7 / 2 with stall active
    drive(4'd4, 32'd7, 32'd2, 1'b1, 1'b0);
    idle(11, 1'b1);
    // signed div, stall with and without a dependent D-stage op
    drive(4'd3, 32'd100, 32'd7, 1'b1, 1'b0);
    idle(11, 1'b1);
    drive(4'd3, 32'hFFFFFF9C, 32'd7, 1'b0, 1'b0);
    idle(11, 1'b0);
    // mthi / mfhi / mflo / mtlo
    drive(4'd5, 32'h12345678, 32'd0, 1'b1, 1'b0);
    drive(4'd7, 32'd0, 32'd0, 1'b1, 1'b0);
    drive(4'd8, 32'd0, 32'd0, 1'b1, 1'b0);
    drive(4'd6, 32'hCAFEF00D, 32'd0, 1'b0, 1'b0);
    drive(4'd8, 32'd0, 32'd0, 1'b0, 1'b0);
    // cancel in 3rd busy cycle of a multu
    drive(4'd2, 32'hFFFFFFFF, 32'hFFFFFFFF, 1'b0, 1'b0);
    idle(2, 1'b0);
    drive(4'd0, 32'd0, 32'd0, 1'b0, 1'b1);
    idle(2, 1'b0);
    // cancel on the final busy cycle
    drive(4'd1, 32'd9, 32'd9, 1'b0, 1'b0);
    idle(4, 1'b0);
    drive(4'd0, 32'd0, 32'd0, 1'b0, 1'b1);
    idle(2, 1'b0);
    // cancel together with mthi and with a start
    drive(4'd5, 32'hDEAD0000, 32'd0, 1'b0, 1'b1);
    drive(4'd1, 32'd5, 32'd5, 1'b1, 1'b1);
    drive(4'd7, 32'd0, 32'd0, 1'b0, 1'b0);
    // ops issued while running are ignored
    drive(4'd1, 32'd6, 32'd7, 1'b0, 1'b0);
    drive(4'd5, 32'h55555555, 32'd0, 1'b1, 1'b0);
    drive(4'd3, 32'd50, 32'd5, 1'b1, 1'b0);
    drive(4'd6, 32'h66666666, 32'd0, 1'b0, 1'b0);
    idle(4, 1'b0);
    // reset during 4th busy cycle of a div
    drive(4'd3, 32'd1000, 32'd3, 1'b0, 1'b0);
    idle(3, 1'b0);
    do_reset();
    idle(12, 1'b0);
    // division by zero and signed overflow
    drive(4'd4, 32'd55, 32'd0, 1'b0, 1'b0);
    idle(11, 1'b0);
    drive(4'd3, 32'h80000000, 32'hFFFFFFFF, 1'b0, 1'b0);
    idle(11, 1'b0);

    // randomized stream
    for (int i = 0; i < 500; i++) begin
      if ($urandom_range(0, 99) < 2) begin
        do_reset();
      end else begin
        logic [3:0] op;
        op = ($urandom_range(0, 3) == 0) ? 4'($urandom_range(0, 15))
                                         : 4'($urandom_range(1, 8));
        drive(op, rnd_val(), rnd_val(), 1'($urandom_range(0, 1)),
              1'($urandom_range(0, 9) == 0));
      end
    end
    idle(12, 1'b0);
    done_req = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/mdu_ctrl.md
MDU_CTRL -- requirements
Module: mdu_ctrl

Interface
REQ-001 SHALL have parameter MULT_LAT, default 5, busy cycles for mult/multu.
REQ-002 SHALL have parameter DIV_LAT, default 10, busy cycles for div/divu.
REQ-003 clk  input  1  clock, all state updates on rising edge.
REQ-004 reset  input  1  reset, synchronous, active-high.
REQ-005 e_op  input  4  E-stage HI/LO op: 0 none, 1 mult, 2 multu, 3 div, 4 divu, 5 mthi, 6 mtlo, 7 mfhi, 8 mflo; 9-15 treated as none.
REQ-006 e_rs  input  32  E-stage forwarded rs value.
REQ-007 e_rt  input  32  E-stage forwarded rt value.
REQ-008 d_uses_md  input  1  D-stage instruction is any of ops 1-8.
REQ-009 cancel  input  1  kill the E-stage op and any running operation.
REQ-010 core_a, core_b  output  32 each  latched operands to the combinational arithmetic core.
REQ-011 core_op  output  2  latched core op: 0 mult, 1 multu, 2 div, 3 divu.
REQ-012 core_hi, core_lo  input  32 each  combinational core results for core_a/core_b/core_op.
REQ-013 hi, lo  output  32 each  architectural HI/LO registers.
REQ-014 e_rd_data  output  32  mfhi/mflo read data for E stage.
REQ-015 busy  output  1  operation in progress.
REQ-016 stall  output  1  freeze F/D, bubble into E.

Function
REQ-017 SHALL implement two states, IDLE and RUN, plus a down-counter wide enough for max(MULT_LAT, DIV_LAT).
REQ-018 start SHALL be asserted combinationally when state is IDLE, e_op is 1-4, and cancel is 0.
REQ-019 On the start edge SHALL latch e_rs->core_a, e_rt->core_b, and e_op-1->core_op; SHALL load the counter with MULT_LAT (ops 1-2) or DIV_LAT (ops 3-4); SHALL enter RUN.
REQ-020 busy SHALL equal (state == RUN); an op started at edge T keeps busy high for exactly MULT_LAT or DIV_LAT cycles after T.
REQ-021 In RUN the counter SHALL decrement each edge; on the edge where the counter equals 1, SHALL write hi<=core_hi, lo<=core_lo, and return to IDLE.
REQ-022 Result SHALL be visible on hi/lo in the first cycle busy is low.
REQ-023 mthi (mtlo) in IDLE with cancel=0 SHALL write hi (lo) <= e_rs at the edge; the other register is unchanged.
REQ-024 e_rd_data SHALL be hi for op 7, lo for op 8, else 0, combinationally from the current register values.
REQ-025 Any e_op other than none while in RUN SHALL be ignored; the pipeline prevents it via stall.
REQ-026 stall SHALL equal d_uses_md & (busy | start); otherwise stall SHALL be 0.
REQ-027 cancel in RUN SHALL return the block to IDLE at the next edge, with hi/lo unchanged and the counter cleared; this holds even when the counter equals 1.
REQ-028 cancel together with a start or mthi/mtlo in the same cycle SHALL suppress that op; no state change.
REQ-029 core_a/core_b/core_op SHALL hold their values outside start edges.
REQ-030 Division by zero SHALL not be special-cased; whatever core_hi/core_lo present is committed.

Reset
REQ-031 reset SHALL take priority over all inputs including cancel.
REQ-032 On reset: state IDLE, counter 0, hi=lo=0, core_a=core_b=0, core_op=0; therefore busy=0 and stall=0 in the following cycle.
REQ-033 reset asserted in RUN SHALL abort the operation with no HI/LO commit.
REQ-034 The initial power-up state SHALL match the reset state.

Verification
REQ-035 The bench SHALL model the core behaviourally (signed/unsigned 64-bit product; quotient to LO, remainder to HI) and cover the following scenarios.
REQ-036 Scenario mult: e_rs=3, e_rt=0xFFFFFFFE, op 1 at T -> busy high for cycles T+1..T+5; hi=0xFFFFFFFF and lo=0xFFFFFFFA at T+6.
REQ-037 Scenario divu: e_rs=7, e_rt=2, op 4 -> busy for 10 cycles, then hi=1 and lo=3.
REQ-038 Scenario stall: op 3 in E with d_uses_md=1 -> stall high during the start cycle and all 10 busy cycles, low the cycle busy drops; with d_uses_md=0, stall stays 0 throughout.
REQ-039 Scenario mthi/mflo: mthi with e_rs=0x12345678, then mfhi next cycle -> e_rd_data=0x12345678; lo unchanged.
REQ-040 Scenario cancel: op 1 started, cancel at the 3rd busy cycle -> busy low next cycle and hi/lo keep prior values; cancel with op 5 -> hi unchanged.
REQ-041 Scenario reset: reset during the 4th busy cycle of a div -> busy=0, hi=lo=0 next cycle, and no later commit.
